// File: rtl/vip_pkg.sv
// rtl/vip_pkg.sv - shared types, default geometry and pixel packing for VIP frame capture
package vip_pkg;

  // Capture controller states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2
  } vip_state_t;

  // Default active frame geometry
  localparam int VIP_HDISP_DEF = 640;
  localparam int VIP_VDISP_DEF = 480;

  // Width of the x/y pixel counters; both saturate at all-ones
  localparam int VIP_CNT_W = 12;

  // {B,G,R} 8:8:8 field positions inside a 24-bit pixel
  localparam int PIX_B_MSB = 23;
  localparam int PIX_B_LSB = 16;
  localparam int PIX_G_MSB = 15;
  localparam int PIX_G_LSB = 8;
  localparam int PIX_R_MSB = 7;
  localparam int PIX_R_LSB = 0;

  // Assemble a 24-bit pixel from its three colour components
  function automatic logic [23:0] vip_pack_bgr(input logic [7:0] b,
                                               input logic [7:0] g,
                                               input logic [7:0] r);
    logic [23:0] p;
    p = '0;
    p[PIX_B_MSB:PIX_B_LSB] = b;
    p[PIX_G_MSB:PIX_G_LSB] = g;
    p[PIX_R_MSB:PIX_R_LSB] = r;
    return p;
  endfunction

endpackage

// File: rtl/vip_frame_capture_if.sv
// rtl/vip_frame_capture_if.sv - VIP video input and frame-buffer write port bundle
interface vip_frame_capture_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 19
);

  // Incoming VIP video stream
  logic              in_vsync;
  logic              in_href;
  logic              in_clken;
  logic [DATA_W-1:0] in_data;

  // Linear frame-buffer write port
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Capture block: consumes video, drives the RAM write port
  modport master (
    input  in_vsync, in_href, in_clken, in_data,
    output wr_en, wr_addr, wr_data
  );

  // Video source / RAM side: drives video, observes the write port
  modport slave (
    output in_vsync, in_href, in_clken, in_data,
    input  wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/vip_sync_edge.sv
// rtl/vip_sync_edge.sv - registers vsync/href and flags start-of-frame, end-of-frame and end-of-line
module vip_sync_edge #(
  parameter logic VSYNC_RST = 1'b1,
  parameter logic HREF_RST  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic href,
  output logic sof,
  output logic eof,
  output logic eol
);

  logic vsync_d;
  logic href_d;

  // One-cycle delayed copies; reset values chosen so leaving reset mid-frame gives no false edge
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d <= VSYNC_RST;
      href_d  <= HREF_RST;
    end else begin
      vsync_d <= vsync;
      href_d  <= href;
    end
  end

  assign sof = vsync & ~vsync_d;
  assign eof = ~vsync & vsync_d;
  assign eol = ~href & href_d;

endmodule

// File: rtl/vip_frame_capture.sv
// rtl/vip_frame_capture.sv - captures one VIP frame into a linear frame-buffer write stream (VIP_CAPTURE_CONTINUOUS_EN: capture every frame after arm)
module vip_frame_capture
  import vip_pkg::*;
#(
  parameter int IMG_HDISP = VIP_HDISP_DEF,
  parameter int IMG_VDISP = VIP_VDISP_DEF,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  vip_frame_capture_if.master vif,
  output logic                busy,
  output logic                frame_done,
  output logic                err_line,
  output logic                err_frame,
  output logic [15:0]         frame_cnt
);

  localparam int XW = VIP_CNT_W;
  localparam logic [XW-1:0]     CNT_MAX = {XW{1'b1}};
  localparam logic [XW-1:0]     HDISP_X = XW'(IMG_HDISP);
  localparam logic [XW-1:0]     VDISP_Y = XW'(IMG_VDISP);
  localparam logic [ADDR_W-1:0] HDISP_A = ADDR_W'(IMG_HDISP);

  vip_state_t state_q, state_d;

  logic sof, eof, eol;
  logic arm_go, start_cap, end_cap;
  logic pix_acc, pix_in_win;
  logic [XW-1:0] x_q, y_q, x_inc, y_next;
  logic [ADDR_W-1:0] line_base_q;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              frame_done_q;
  logic              err_line_q;
  logic              err_frame_q;
  logic [15:0]       frame_cnt_q;

  vip_sync_edge #(
    .VSYNC_RST (1'b1),
    .HREF_RST  (1'b0)
  ) u_sync_edge (
    .clk   (clk),
    .rst   (rst),
    .vsync (vif.in_vsync),
    .href  (vif.in_href),
    .sof   (sof),
    .eof   (eof),
    .eol   (eol)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic plus one-cycle control strobes for the datapath
  always_comb begin
    state_d   = state_q;
    arm_go    = 1'b0;
    start_cap = 1'b0;
    end_cap   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_WAIT_SOF;
          arm_go  = 1'b1;
        end
      end
      ST_WAIT_SOF: begin
        if (sof) begin
          state_d   = ST_CAPTURE;
          start_cap = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (eof) begin
          end_cap = 1'b1;
`ifdef VIP_CAPTURE_CONTINUOUS_EN
          state_d = ST_WAIT_SOF;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel acceptance, write window and saturating counter increments.
  // A pixel in the eof cycle is not written so wr_en never meets frame_done.
  // y_next already includes a same-cycle eol so eof sees the updated line count.
  always_comb begin
    pix_acc    = (state_q == ST_CAPTURE) & vif.in_href & vif.in_clken & ~eof;
    pix_in_win = (x_q < HDISP_X) && (y_q < VDISP_Y);
    x_inc      = (x_q == CNT_MAX) ? x_q : x_q + 1'b1;
    y_next     = y_q;
    if (eol) y_next = (y_q == CNT_MAX) ? y_q : y_q + 1'b1;
  end

  // Counters, write port, error flags and frame statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      line_base_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_line_q   <= 1'b0;
      err_frame_q  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;

      if (arm_go) begin
        err_line_q  <= 1'b0;
        err_frame_q <= 1'b0;
      end

      if (start_cap) begin
        x_q         <= '0;
        y_q         <= '0;
        line_base_q <= '0;
`ifdef VIP_CAPTURE_CONTINUOUS_EN
        err_line_q  <= 1'b0;
        err_frame_q <= 1'b0;
`endif
      end

      if (pix_acc) begin
        x_q <= x_inc;
        if (pix_in_win) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= line_base_q + ADDR_W'(x_q);
          wr_data_q <= vif.in_data;
        end
      end

      if ((state_q == ST_CAPTURE) && eol) begin
        if (x_q != HDISP_X) err_line_q <= 1'b1;
        y_q         <= y_next;
        line_base_q <= line_base_q + HDISP_A;
        x_q         <= '0;
      end

      if (end_cap) begin
        if (y_next != VDISP_Y) err_frame_q <= 1'b1;
        frame_done_q <= 1'b1;
        frame_cnt_q  <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign vif.wr_en   = wr_en_q;
  assign vif.wr_addr = wr_addr_q;
  assign vif.wr_data = wr_data_q;

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign err_line   = err_line_q;
  assign err_frame  = err_frame_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/vip_frame_capture.md
Name: vip_frame_capture

Overview:
Receiving end of the VIP video stream interface (vsync/href/clken/24-bit pixel), as driven by the CMOS-timing generator and the picture_process outputs. On request, it captures exactly one frame and converts it into a linear write stream for a frame-buffer RAM port. Per frame it also reports line-length and frame-height errors, a done pulse and a frame count. It is the synthesizable counterpart of the capture loop used in simulation, so captured results can be read back on-chip.

Parameters:
IMG_HDISP, 640, active pixels per line
IMG_VDISP, 480, active lines per frame
ADDR_W, 19, frame-buffer word address width (must satisfy 2^ADDR_W >= IMG_HDISP*IMG_VDISP)
DATA_W, 24, pixel width ({B,G,R} 8:8:8 packing, passed through unmodified)

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
arm  in  1  one-cycle request: capture the next complete frame
in_vsync  in  1  frame sync; low = sync interval, rising edge = start of frame, falling edge = end of frame
in_href  in  1  line valid
in_clken  in  1  pixel qualifier; a pixel is accepted when in_href & in_clken
in_data  in  DATA_W  pixel data
wr_en  out  1  frame-buffer write strobe
wr_addr  out  ADDR_W  word address = y*IMG_HDISP + x
wr_data  out  DATA_W  pixel to write
busy  out  1  high in WAIT_SOF and CAPTURE
frame_done  out  1  one-cycle pulse at end of a captured frame
err_line  out  1  sticky: some line in the last frame had a pixel count other than IMG_HDISP
err_frame  out  1  sticky: last frame had a line count other than IMG_VDISP
frame_cnt  out  16  number of completed captures, wraps at 65535 to 0

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state = IDLE.
  - All outputs 0.
  - x, y and line_base counters = 0.
  - vsync_d = 1 and href_d = 0, so no false start-of-frame is seen when leaving reset mid-frame.
  - Reset asserted mid-capture abandons the frame; no frame_done is issued.
- Edge detection uses a one-cycle registered copy of in_vsync and in_href:
  - sof = in_vsync & ~vsync_d
  - eof = ~in_vsync & vsync_d
  - eol = ~in_href & href_d
- State machine:
  - IDLE: arm -> WAIT_SOF. On entry to WAIT_SOF, clear err_line and err_frame.
  - WAIT_SOF: sof -> CAPTURE, with x = y = line_base = 0. Pixels arriving before sof are ignored.
  - CAPTURE:
    - Accepted pixel with x < IMG_HDISP and y < IMG_VDISP: next cycle wr_en = 1, wr_addr = line_base + x, wr_data = in_data. Then x++.
    - Accepted pixel with x >= IMG_HDISP or y >= IMG_VDISP: dropped (no write). x still counts, saturating at 2^12-1.
    - eol: if x != IMG_HDISP, set err_line. Then y++ (saturating), line_base += IMG_HDISP, x = 0.
    - eof: if y != IMG_VDISP, set err_frame. Next cycle: frame_done = 1, frame_cnt++, go to IDLE.
  - arm is ignored outside IDLE.
- Latency: input pixel to wr_en is exactly 1 cycle. frame_done follows the eof cycle by 1.
- Simultaneous eol and eof (href and vsync fall in the same cycle): process eol first (line check and y++), then evaluate eof using the updated y.
- A pixel accepted in the same cycle as eol does not occur, since eol implies in_href = 0.
- No multiplier: the address is line_base + x. The adder is ADDR_W bits wide, with x zero-extended.
- frame_done and wr_en are never high in the same cycle.

Optional Feature:
VIP_CAPTURE_CONTINUOUS_EN
- Defined: on eof the FSM goes directly to WAIT_SOF instead of IDLE. Errors are cleared at each sof. The block captures every frame after the first arm until rst; busy stays high.
- Undefined: single-shot behaviour as above; arm is required for each frame.

Decomposition:
- Shared package vip_pkg holds:
  - state enum (IDLE, WAIT_SOF, CAPTURE)
  - default IMG_HDISP/IMG_VDISP constants (640/480)
  - pixel packing field offsets (B 23:16, G 15:8, R 7:0)
- One natural sub-module: vip_sync_edge, which registers vsync/href and produces sof/eof/eol with a configurable reset value per input.
- Counters and FSM stay in the top module.

Test Plan:
1. IMG_HDISP=8, IMG_VDISP=4. arm, then one clean frame with data = pixel index -> 32 writes, wr_addr 0..31, wr_data == index, frame_done once, frame_cnt = 1, both errors 0.
2. Line 2 carries 7 pixels -> err_line = 1. Writes for addresses 16..22 only; address 23 is never written. err_frame = 0.
3. Frame with 5 lines -> err_frame = 1. The fifth line produces no wr_en. frame_done still pulses.
4. No arm, two frames driven -> wr_en never asserts and frame_cnt = 0. Then arm asserted mid-frame -> the remainder of that frame is ignored and the next full frame is captured.
5. rst pulsed during line 1 of a capture -> all outputs 0 next cycle and state IDLE. A following arm plus clean frame captures normally.
6. With VIP_CAPTURE_CONTINUOUS_EN: arm once, three frames -> 96 writes, three frame_done pulses, frame_cnt = 3, busy held high throughout.
